// File: rtl/dmem_access_ctrl.sv
// Two-port arbiter/sequencer in front of a single-port word-wide data memory.
// Handles byte/half/word loads and stores; sub-word stores use read-modify-write.
module dmem_access_ctrl #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [1:0]    a_size,
    input  logic          a_unsigned,
    input  logic [31:0]   a_wdata,
    output logic          a_resp_valid,
    output logic [31:0]   a_resp_rdata,
    output logic          a_resp_err,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [1:0]    b_size,
    input  logic          b_unsigned,
    input  logic [31:0]   b_wdata,
    output logic          b_resp_valid,
    output logic [31:0]   b_resp_rdata,
    output logic          b_resp_err,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t        state, state_d;
    logic          last_b, cur_b;
    logic          t_we, t_uns;
    logic [1:0]    t_size, t_off;

    logic          grant_a, grant_b, accept, misalign;
    logic          sel_we, sel_uns;
    logic [AW-1:0] sel_addr;
    logic [1:0]    sel_size;
    logic [31:0]   sel_wdata;

    logic          owner_d, err_d, mem_read_d, mem_write_d;
    logic          a_rv_d, b_rv_d;
    logic [31:0]   rdata_d;

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   load_ext = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_ext = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_ext = word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wd,
                                          input logic [1:0] off, input logic [1:0] size);
        logic [31:0] r;
        r = word;
        if (size == 2'b00) r[{off, 3'b000} +: 8] = wd[7:0];
        else               r[{off[1], 4'b0000} +: 16] = wd[15:0];
        return r;
    endfunction

    // Round-robin: on contention the port not granted last time wins.
    always_comb begin
        grant_a   = a_valid && (!b_valid || last_b);
        grant_b   = b_valid && !grant_a;
        accept    = (state == IDLE) && !reset && (grant_a || grant_b);
        a_ready   = accept && grant_a;
        b_ready   = accept && grant_b;
        sel_we    = grant_b ? b_we       : a_we;
        sel_addr  = grant_b ? b_addr     : a_addr;
        sel_size  = grant_b ? b_size     : a_size;
        sel_uns   = grant_b ? b_unsigned : a_unsigned;
        sel_wdata = grant_b ? b_wdata    : a_wdata;
        misalign  = sel_size[1] ? (sel_addr[1:0] != 2'b00) : (sel_size[0] && sel_addr[0]);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (reset) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (misalign)                 state_d = RESP;
                    else if (sel_we && sel_size[1]) state_d = WRITE;
                    else                          state_d = READ;
                end
                READ:    state_d = t_we ? WRITE : RESP;
                WRITE:   state_d = RESP;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values for the registered memory strobes and responses.
    always_comb begin
        owner_d     = (state == IDLE) ? grant_b : cur_b;
        err_d       = (state == IDLE) && misalign;
        mem_read_d  = (state_d == READ);
        mem_write_d = (state_d == WRITE);
        a_rv_d      = (state_d == RESP) && !owner_d;
        b_rv_d      = (state_d == RESP) && owner_d;
        rdata_d     = 32'd0;
        if (state == READ && !t_we) rdata_d = load_ext(mem_rdata, t_off, t_size, t_uns);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_b       <= 1'b1;
            cur_b        <= 1'b0;
            t_we         <= 1'b0;
            t_uns        <= 1'b0;
            t_size       <= 2'b00;
            t_off        <= 2'b00;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            a_resp_valid <= 1'b0;
            a_resp_err   <= 1'b0;
            a_resp_rdata <= 32'd0;
            b_resp_valid <= 1'b0;
            b_resp_err   <= 1'b0;
            b_resp_rdata <= 32'd0;
        end else begin
            mem_read     <= mem_read_d;
            mem_write    <= mem_write_d;
            a_resp_valid <= a_rv_d;
            a_resp_err   <= a_rv_d && err_d;
            a_resp_rdata <= a_rv_d ? rdata_d : 32'd0;
            b_resp_valid <= b_rv_d;
            b_resp_err   <= b_rv_d && err_d;
            b_resp_rdata <= b_rv_d ? rdata_d : 32'd0;
            if (accept) begin
                last_b    <= grant_b;
                cur_b     <= grant_b;
                t_we      <= sel_we;
                t_uns     <= sel_uns;
                t_size    <= sel_size;
                t_off     <= sel_addr[1:0];
                mem_addr  <= {sel_addr[AW-1:2], 2'b00};
                mem_wdata <= sel_wdata;
            end
            // Sub-word store: splice new lanes into the word just read.
            if (state == READ && t_we) mem_wdata <= merge(mem_rdata, mem_wdata, t_off, t_size);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural word memory.
module tb_dmem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_ready, a_we, a_unsigned, a_resp_valid, a_resp_err;
    logic [7:0]  a_addr;
    logic [1:0]  a_size;
    logic [31:0] a_wdata, a_resp_rdata;
    logic        b_valid, b_ready, b_we, b_unsigned, b_resp_valid, b_resp_err;
    logic [7:0]  b_addr;
    logic [1:0]  b_size;
    logic [31:0] b_wdata, b_resp_rdata;
    logic        mem_read, mem_write, busy;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:63] = '{default: 32'd0};
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

    dmem_access_ctrl #(.AW(8)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_size(a_size),
        .a_unsigned(a_unsigned), .a_wdata(a_wdata), .a_resp_valid(a_resp_valid),
        .a_resp_rdata(a_resp_rdata), .a_resp_err(a_resp_err),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_size(b_size),
        .b_unsigned(b_unsigned), .b_wdata(b_wdata), .b_resp_valid(b_resp_valid),
        .b_resp_rdata(b_resp_rdata), .b_resp_err(b_resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on a port; reports latency from accept and what the memory saw.
    task automatic run(input bit pb, input bit we, input logic [7:0] addr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er,
                       output bit srd, output bit swr, output bit wrongp,
                       output logic [7:0] wa, output logic [31:0] wdv);
        int w;
        lat = -1; rd = 'x; er = 'x; srd = 0; swr = 0; wrongp = 0; wa = 'x; wdv = 'x;
        @(negedge clk);
        if (pb) begin b_valid = 1; b_we = we; b_addr = addr; b_size = sz; b_unsigned = uns; b_wdata = wd; end
        else    begin a_valid = 1; a_we = we; a_addr = addr; a_size = sz; a_unsigned = uns; a_wdata = wd; end
        #1;
        w = 0;
        while (!(pb ? b_ready : a_ready) && w < 20) begin
            @(negedge clk); #1; w++;
        end
        if (w >= 20) begin
            n_cmp++; n_err++;
            $error("FAIL ready_timeout: observed no ready expected ready");
            a_valid = 0; b_valid = 0;
            return;
        end
        @(negedge clk);
        a_valid = 0; b_valid = 0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            srd |= mem_read;
            if (mem_write) begin swr = 1; wa = mem_addr; wdv = mem_wdata; end
            wrongp |= (pb ? a_resp_valid : b_resp_valid);
            if (pb ? b_resp_valid : a_resp_valid) begin
                lat = c;
                rd  = pb ? b_resp_rdata : a_resp_rdata;
                er  = pb ? b_resp_err : a_resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_a_resp", {a_resp_valid, a_resp_err, b_resp_valid, b_resp_err}, 0);
        chk("rst_rdata", a_resp_rdata | b_resp_rdata, 0);
        reset = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, g[8], ng;
        logic [31:0] rd, wdv;
        logic er;
        logic [7:0] wa;
        bit srd, swr, wp, seen;

        reset = 1;
        a_valid = 0; a_we = 0; a_addr = 0; a_size = 0; a_unsigned = 0; a_wdata = 0;
        b_valid = 0; b_we = 0; b_addr = 0; b_size = 0; b_unsigned = 0; b_wdata = 0;
        do_reset();

        // Preload through word stores (also exercises SW latency).
        run(0, 1, 8'h04, 2'b10, 0, 32'h0000_0002, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("sw_lat", lat, 2);
        chk("sw_no_read", srd, 0);
        chk("sw_wdata", wdv, 32'h0000_0002);
        chk("sw_resp_rdata", rd, 0);
        run(0, 1, 8'h08, 2'b10, 0, 32'h0000_0003, lat, rd, er, srd, swr, wp, wa, wdv);
        run(1, 1, 8'h10, 2'b10, 0, 32'h1111_AAAA, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("sw_b_lat", lat, 2);
        run(0, 1, 8'h14, 2'b10, 0, 32'h2222_BBBB, lat, rd, er, srd, swr, wp, wa, wdv);
        run(0, 1, 8'h00, 2'b11, 0, 32'h8001_0000, lat, rd, er, srd, swr, wp, wa, wdv);
        run(0, 1, 8'h20, 2'b10, 0, 32'h1122_3344, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("mem_preload_00", mem[0], 32'h8001_0000);
        chk("mem_preload_20", mem[8], 32'h1122_3344);

        // LW 0x04 immediately after reset, cycle by cycle.
        do_reset();
        @(negedge clk);
        a_valid = 1; a_we = 0; a_addr = 8'h04; a_size = 2'b10; a_unsigned = 0;
        #1 chk("lw_ready_c0", a_ready, 1);
        chk("lw_b_ready_c0", b_ready, 0);
        @(negedge clk);
        a_valid = 0;
        #1 chk("lw_mem_read_c1", mem_read, 1);
        chk("lw_mem_addr_c1", mem_addr, 8'h04);
        chk("lw_no_resp_c1", a_resp_valid, 0);
        chk("lw_busy_c1", busy, 1);
        @(negedge clk);
        #1 chk("lw_resp_c2", a_resp_valid, 1);
        chk("lw_rdata_c2", a_resp_rdata, 32'h0000_0002);
        chk("lw_err_c2", a_resp_err, 0);
        chk("lw_mem_read_c2", mem_read, 0);
        @(negedge clk);
        #1 chk("lw_idle_c3", busy, 0);
        chk("lw_resp_gone_c3", a_resp_valid, 0);

        // Contention: both held valid; grants must alternate starting with A.
        do_reset();
        for (int i = 0; i < 8; i++) g[i] = -1;
        ng = 0;
        @(negedge clk);
        a_valid = 1; a_we = 0; a_addr = 8'h10; a_size = 2'b10;
        b_valid = 1; b_we = 0; b_addr = 8'h14; b_size = 2'b10;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (a_ready && ng < 8) begin g[ng] = 0; ng++; end
            if (b_ready && ng < 8) begin g[ng] = 1; ng++; end
            if (a_resp_valid) begin
                chk("alt_a_rdata", a_resp_rdata, 32'h1111_AAAA);
                chk("alt_a_only", b_resp_valid, 0);
            end
            if (b_resp_valid) begin
                chk("alt_b_rdata", b_resp_rdata, 32'h2222_BBBB);
                chk("alt_b_only", a_resp_valid, 0);
            end
            @(negedge clk);
        end
        a_valid = 0; b_valid = 0;
        chk("alt_grant0", g[0], 0);
        chk("alt_grant1", g[1], 1);
        chk("alt_grant2", g[2], 0);
        chk("alt_grant3", g[3], 1);
        repeat (4) @(negedge clk);

        // SB via B: read-modify-write.
        run(1, 1, 8'h09, 2'b00, 0, 32'h0000_00AB, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("sb_lat", lat, 3);
        chk("sb_read", srd, 1);
        chk("sb_write", swr, 1);
        chk("sb_waddr", wa, 8'h08);
        chk("sb_wdata", wdv, 32'h0000_AB03);
        chk("sb_err", er, 0);
        chk("sb_rdata", rd, 0);
        chk("sb_other_port", wp, 0);
        chk("sb_mem", mem[2], 32'h0000_AB03);

        // Sign/zero extension on loads.
        run(0, 1, 8'h08, 2'b10, 0, 32'h0080_0000, lat, rd, er, srd, swr, wp, wa, wdv);
        run(0, 0, 8'h0A, 2'b00, 0, 32'h0, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("lb_rdata", rd, 32'hFFFF_FF80);
        chk("lb_lat", lat, 2);
        run(1, 0, 8'h0A, 2'b00, 1, 32'h0, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("lbu_rdata", rd, 32'h0000_0080);
        run(0, 0, 8'h02, 2'b01, 0, 32'h0, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("lh_rdata", rd, 32'hFFFF_8001);
        run(0, 0, 8'h02, 2'b01, 1, 32'h0, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("lhu_rdata", rd, 32'h0000_8001);
        run(0, 0, 8'h03, 2'b00, 0, 32'h0, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("lb_top_lane", rd, 32'hFFFF_FF80);

        // Half store into the upper lanes.
        run(0, 1, 8'h22, 2'b01, 0, 32'h1234_BEEF, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("sh_lat", lat, 3);
        chk("sh_mem", mem[8], 32'hBEEF_3344);

        // Misaligned accesses.
        run(0, 0, 8'h06, 2'b10, 0, 32'h0, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("lw_mis_err", er, 1);
        chk("lw_mis_rdata", rd, 0);
        chk("lw_mis_no_read", srd, 0);
        chk("lw_mis_lat", lat, 1);
        run(1, 1, 8'h03, 2'b01, 0, 32'hFFFF, lat, rd, er, srd, swr, wp, wa, wdv);
        chk("sh_mis_err", er, 1);
        chk("sh_mis_no_write", swr, 0);
        chk("sh_mis_no_read", srd, 0);
        chk("sh_mis_mem", mem[0], 32'h8001_0000);

        // Reset during the READ of an SB.
        @(negedge clk);
        b_valid = 1; b_we = 1; b_addr = 8'h21; b_size = 2'b00; b_wdata = 32'h55;
        #1 chk("rst_mid_ready", b_ready, 1);
        @(negedge clk);
        b_valid = 0;
        #1 chk("rst_mid_in_read", mem_read, 1);
        reset = 1;
        @(negedge clk);
        #1 chk("rst_mid_idle", busy, 0);
        chk("rst_mid_strobes", {mem_read, mem_write}, 0);
        reset = 0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 seen |= mem_write | a_resp_valid | b_resp_valid;
        end
        chk("rst_mid_quiet", seen, 0);
        chk("rst_mid_mem", mem[8], 32'hBEEF_3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
